match_fsm: RTL
==============

MATCH_FSM -- requirements
Module: match_fsm

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7: points needed to win a match.
REQ-002 SHALL have parameter SCORE_W, default 4: score counter width; MAX = 2^SCORE_W-1.
REQ-003 SHALL have parameter INTRO_CYC, default 100000000: clock cycles spent in INTRO.
REQ-004 SHALL have parameter SERVE_CYC, default 50000000: clock cycles spent in SERVE_WAIT.
REQ-005 SHALL have parameter NET_X, default 180: ball_x at or above this value means the ball landed on the NPC side.
REQ-006 SHALL have parameter FLOOR_Y, default 220, and parameter BALL_H, default 30: floor-touch threshold and ball height.
REQ-007 SHALL have parameter DEUCE_EN, default 1: when 1, a match is won only with a lead of at least 2.
REQ-008 SHALL have port clk, input, 1 bit: the single system clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port start_n, input, 1 bit: level input; 0 requests start, 1 requests return to idle.
REQ-011 SHALL have port pause, input, 1 bit: level input; 1 freezes the match.
REQ-012 SHALL have ports ball_x and ball_y, input, 12 bits each: ball position.
REQ-013 SHALL have port game_state, output, 3 bits: 0 intro, 1 serve wait, 2 play, 3 end, 4 idle/other.
REQ-014 SHALL have port who_win, output, 1 bit: last scorer; 0 = player, 1 = NPC.
REQ-015 SHALL have ports player_score and npc_score, output, SCORE_W bits each.
REQ-016 SHALL have port point_pulse, output, 1 bit: one-cycle strobe on each scored point.
REQ-017 SHALL have port match_over, output, 1 bit, and port winner, output, 1 bit (0 = player, 1 = NPC).
REQ-018 SHALL have port frozen, output, 1 bit: high while the match is paused.

Function
REQ-019 SHALL implement the states IDLE, INTRO, SERVE_WAIT, PLAY, SCORE, CHECK and OVER, with all state and outputs registered.
REQ-020 SHALL, in IDLE with start_n=0, go to INTRO next cycle and clear both scores, match_over, winner and who_win on that transition.
REQ-021 SHALL remain in INTRO for exactly INTRO_CYC unpaused cycles, then go to SERVE_WAIT.
REQ-022 SHALL remain in SERVE_WAIT for exactly SERVE_CYC unpaused cycles, then go to PLAY; the cycle counter clears on entry to each timed state.
REQ-023 SHALL detect a touch when ball_y+BALL_H >= FLOOR_Y, computed at 13 bits with no wrap; touch is sampled only in PLAY.
REQ-024 SHALL, on a touch in PLAY, go to SCORE next cycle.
REQ-025 SHALL, on the PLAY->SCORE transition, award the point by the sampled ball_x: ball_x >= NET_X (including exactly NET_X) gives player_score +1 and who_win=0; otherwise npc_score +1 and who_win=1.
REQ-026 SHALL assert point_pulse for exactly the single SCORE cycle; SCORE always goes to CHECK next cycle.
REQ-027 SHALL, in CHECK, declare a win when the scorer's score >= WIN_SCORE and either DEUCE_EN=0 or the scorer leads by at least 2; the match then goes to OVER with match_over=1 and winner set to the scorer.
REQ-028 SHALL, in CHECK, also declare a win for the scorer when the scorer's score equals MAX, regardless of lead; otherwise CHECK returns to SERVE_WAIT.
REQ-029 SHALL never increment a score beyond MAX.
REQ-030 SHALL, in OVER, hold the scores and winner, and go to IDLE when start_n=1; match_over stays asserted until the next INTRO entry.
REQ-031 SHALL drive game_state as IDLE=4, INTRO=0, SERVE_WAIT=1, PLAY=2, SCORE=4, CHECK=4, OVER=3.
REQ-032 SHALL, while pause=1 in INTRO, SERVE_WAIT or PLAY, hold the state, the counter and game_state, ignore touch, and assert frozen=1; pause SHALL be ignored in all other states.

Reset
REQ-033 SHALL, on reset_n=0 at any time including mid-match, immediately set state IDLE, counter 0, game_state=4, both scores 0, and who_win, point_pulse, match_over, winner and frozen all 0.
REQ-034 SHALL begin normal operation on the first clk edge after reset_n deasserts.

Verification (INTRO_CYC=10, SERVE_CYC=5)
REQ-035 SHALL verify the intro sequence: start_n=0 from IDLE -> game_state reads 0 for 10 cycles, then 1 for 5 cycles, then 2.
REQ-036 SHALL verify the net boundary: touches at ball_x=180 -> player_score=1, who_win=0; at ball_x=179 -> npc_score=1, who_win=1; one point_pulse each.
REQ-037 SHALL verify deuce: scores 6-6 then a player point -> 7-6 returns to SERVE_WAIT; another player point -> 8-6, match_over=1, winner=0, game_state=3.
REQ-038 SHALL verify no deuce: with DEUCE_EN=0, a player point at 6-6 -> match ends at 7-6.
REQ-039 SHALL verify pause: pause=1 for 20 cycles during SERVE_WAIT with 2 cycles remaining -> frozen=1, no transition; after release, PLAY is entered 2 cycles later; a touch during pause is not scored.
REQ-040 SHALL verify mid-match reset: reset_n=0 in PLAY at score 3-2 -> all outputs at reset values within the same cycle, with no clk edge required.

Source files
------------

// File: rtl/match_fsm.sv
// Match sequencer for a two-sided ball game: intro and serve timers, floor-touch
// scoring against a net line, deuce-aware win check, pause freeze. All outputs registered.
module match_fsm #(
  parameter int WIN_SCORE = 7,
  parameter int SCORE_W   = 4,
  parameter int INTRO_CYC = 100000000,
  parameter int SERVE_CYC = 50000000,
  parameter int NET_X     = 180,
  parameter int FLOOR_Y   = 220,
  parameter int BALL_H    = 30,
  parameter int DEUCE_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_n,
  input  logic               pause,
  input  logic [11:0]        ball_x,
  input  logic [11:0]        ball_y,
  output logic [2:0]         game_state,
  output logic               who_win,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] npc_score,
  output logic               point_pulse,
  output logic               match_over,
  output logic               winner,
  output logic               frozen
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INTRO = 3'd1;
  localparam logic [2:0] S_SERVE = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_SCORE = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  localparam int CNT_MAX = (INTRO_CYC > SERVE_CYC) ? INTRO_CYC : SERVE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam logic [SCORE_W-1:0] MAX_SC = {SCORE_W{1'b1}};

  logic [2:0]         r_state;
  logic [2:0]         w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_game_state;
  logic               r_who_win;
  logic [SCORE_W-1:0] r_player;
  logic [SCORE_W-1:0] r_npc;
  logic               r_pulse;
  logic               r_over;
  logic               r_winner;
  logic               r_frozen;

  logic               w_timed;
  logic               w_touch;
  logic               w_intro_done;
  logic               w_serve_done;
  logic [SCORE_W-1:0] w_s;
  logic [SCORE_W-1:0] w_o;
  logic               w_lead_ok;
  logic               w_win;

  function automatic logic [2:0] f_gs(input logic [2:0] s);
    case (s)
      S_INTRO: f_gs = 3'd0;
      S_SERVE: f_gs = 3'd1;
      S_PLAY:  f_gs = 3'd2;
      S_OVER:  f_gs = 3'd3;
      default: f_gs = 3'd4;
    endcase
  endfunction

  assign w_timed      = (r_state == S_INTRO) || (r_state == S_SERVE) || (r_state == S_PLAY);
  // 13-bit sum so a ball near the bottom of the 12-bit range cannot wrap past the floor
  assign w_touch      = ({1'b0, ball_y} + 13'(BALL_H)) >= 13'(FLOOR_Y);
  assign w_intro_done = (r_cnt >= CNT_W'(INTRO_CYC - 1));
  assign w_serve_done = (r_cnt >= CNT_W'(SERVE_CYC - 1));

  assign w_s       = r_who_win ? r_npc : r_player;
  assign w_o       = r_who_win ? r_player : r_npc;
  assign w_lead_ok = ({1'b0, w_s} >= ({1'b0, w_o} + (SCORE_W+1)'(2)));
  assign w_win     = (({1'b0, w_s} >= (SCORE_W+1)'(WIN_SCORE)) && ((DEUCE_EN == 0) || w_lead_ok))
                   || (w_s == MAX_SC);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!start_n) w_nxt = S_INTRO;
      S_INTRO: if (!pause && w_intro_done) w_nxt = S_SERVE;
      S_SERVE: if (!pause && w_serve_done) w_nxt = S_PLAY;
      S_PLAY:  if (!pause && w_touch) w_nxt = S_SCORE;
      S_SCORE: w_nxt = S_CHECK;
      S_CHECK: w_nxt = w_win ? S_OVER : S_SERVE;
      S_OVER:  if (start_n) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_game_state <= 3'd4;
      r_who_win    <= 1'b0;
      r_player     <= '0;
      r_npc        <= '0;
      r_pulse      <= 1'b0;
      r_over       <= 1'b0;
      r_winner     <= 1'b0;
      r_frozen     <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_game_state <= f_gs(w_nxt);
      r_frozen     <= pause && w_timed;
      r_pulse      <= (r_state == S_PLAY) && (w_nxt == S_SCORE);

      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (((r_state == S_INTRO) || (r_state == S_SERVE)) && !pause)
        r_cnt <= r_cnt + CNT_W'(1);

      if ((r_state == S_IDLE) && (w_nxt == S_INTRO)) begin
        r_player  <= '0;
        r_npc     <= '0;
        r_over    <= 1'b0;
        r_winner  <= 1'b0;
        r_who_win <= 1'b0;
      end

      // ball on or past the net line landed on the NPC side: player scores
      if ((r_state == S_PLAY) && (w_nxt == S_SCORE)) begin
        if (ball_x >= 12'(NET_X)) begin
          r_who_win <= 1'b0;
          if (r_player != MAX_SC) r_player <= r_player + SCORE_W'(1);
        end else begin
          r_who_win <= 1'b1;
          if (r_npc != MAX_SC) r_npc <= r_npc + SCORE_W'(1);
        end
      end

      if ((r_state == S_CHECK) && w_win) begin
        r_over   <= 1'b1;
        r_winner <= r_who_win;
      end
    end
  end

  assign game_state   = r_game_state;
  assign who_win      = r_who_win;
  assign player_score = r_player;
  assign npc_score    = r_npc;
  assign point_pulse  = r_pulse;
  assign match_over   = r_over;
  assign winner       = r_winner;
  assign frozen       = r_frozen;

endmodule
